// File: rtl/mdu_unit_if.sv
// mdu_unit_if: E-stage MDU request/response bundle between pipeline and multiply/divide unit.
interface mdu_unit_if;
  logic [3:0]  mduOpE;
  logic [31:0] aE;
  logic [31:0] bE;
  logic        startE;
  logic        busyE;
  logic [31:0] outE;
  modport master (output mduOpE, aE, bE, input startE, busyE, outE);
  modport slave  (input mduOpE, aE, bE, output startE, busyE, outE);
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers and MFHI/MFLO/MTHI/MTLO service.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset_n,
  mdu_unit_if.slave   bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, stateN;
  logic [3:0]  cnt, cntN, opL, opN;
  logic [31:0] hi, lo, aL, bL, hiN, loN, aN, bN;
  logic [63:0] mul;
  logic [31:0] aAbs, bAbs, qMag, rMag, quo, rem;
  logic        sgnDiv;
  assign bus.busyE  = state == RUN;
  assign bus.startE = state == IDLE && bus.mduOpE >= 4'd1 && bus.mduOpE <= 4'd4;
  assign bus.outE   = bus.mduOpE == 4'd5 ? hi : bus.mduOpE == 4'd6 ? lo : 32'd0;
  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign mul    = opL == 4'd1 ? {{32{aL[31]}}, aL} * {{32{bL[31]}}, bL} : {32'd0, aL} * {32'd0, bL};
  assign sgnDiv = opL == 4'd3;
  assign aAbs   = sgnDiv && aL[31] ? -aL : aL;
  assign bAbs   = sgnDiv && bL[31] ? -bL : bL;
  assign qMag   = bAbs == 32'd0 ? 32'd0 : aAbs / bAbs;
  assign rMag   = bAbs == 32'd0 ? 32'd0 : aAbs % bAbs;
  // Magnitude divide then re-sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign quo    = sgnDiv && (aL[31] ^ bL[31]) ? -qMag : qMag;
  assign rem    = sgnDiv && aL[31] ? -rMag : rMag;
  always_comb begin
    stateN = state;
    cntN   = cnt;
    hiN    = hi;
    loN    = lo;
    aN     = aL;
    bN     = bL;
    opN    = opL;
    if (state == IDLE) begin
      if (bus.startE) begin
        stateN = RUN;
        cntN   = bus.mduOpE <= 4'd2 ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        aN     = bus.aE;
        bN     = bus.bE;
        opN    = bus.mduOpE;
      end else begin
        hiN = bus.mduOpE == 4'd7 ? bus.aE : hi;
        loN = bus.mduOpE == 4'd8 ? bus.aE : lo;
      end
    end else begin
      cntN = cnt - 4'd1;
      if (cnt == 4'd1) begin
        stateN = IDLE;
        if (opL <= 4'd2) {hiN, loN} = mul;
        else if (bL != 32'd0) {hiN, loN} = {rem, quo};
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      aL    <= 32'd0;
      bL    <= 32'd0;
      opL   <= 4'd0;
    end else begin
      state <= stateN;
      cnt   <= cntN;
      hi    <= hiN;
      lo    <= loN;
      aL    <= aN;
      bL    <= bN;
      opL   <= opN;
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors for mdu_unit with hand-computed HI/LO and Busy/Start timing.
module tb_mdu_unit;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int vecs = 0;
  int errs = 0;
  mdu_unit_if bus ();
  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset_n(rstN), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
    bus.mduOpE = 4'd5;
    #1 chk({tag, " hi"}, bus.outE, expHi);
    bus.mduOpE = 4'd6;
    #1 chk({tag, " lo"}, bus.outE, expLo);
    bus.mduOpE = 4'd0;
  endtask

  // Start op in the current cycle, expect n busy cycles (scrambling operands, presenting busyOp), then idle.
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int n, input logic [3:0] busyOp);
    bus.mduOpE = op;
    bus.aE = a;
    bus.bE = b;
    #1 chk({tag, " start"}, 32'(bus.startE), 32'd1);
    chk({tag, " idle"}, 32'(bus.busyE), 32'd0);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.mduOpE = busyOp;
      bus.aE = $urandom;
      bus.bE = $urandom;
      #1 chk({tag, " busy"}, 32'(bus.busyE), 32'd1);
      chk({tag, " nostart"}, 32'(bus.startE), 32'd0);
    end
    tick();
    bus.mduOpE = 4'd0;
    #1 chk({tag, " done"}, 32'(bus.busyE), 32'd0);
  endtask

  initial begin
    bus.mduOpE = 4'd0;
    bus.aE = 32'd0;
    bus.bE = 32'd0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
    bus.mduOpE = 4'd7;
    bus.aE = 32'hdead;
    tick();
    rstN = 1'b0;
    bus.mduOpE = 4'd0;
    #1 rstN = 1'b1;
    tick();
    rd("reset", 32'd0, 32'd0);
    chk("reset busy", 32'(bus.busyE), 32'd0);
    chk("reset start", 32'(bus.startE), 32'd0);

    run("mult", 4'd1, 32'hfffffffe, 32'd3, 5, 4'd0);
    rd("mult", 32'hffffffff, 32'hfffffffa);
    run("multu", 4'd2, 32'hfffffffe, 32'd3, 5, 4'd0);
    rd("multu", 32'h00000002, 32'hfffffffa);

    run("div", 4'd3, 32'hfffffff9, 32'd2, 10, 4'd0);
    rd("div", 32'hffffffff, 32'hfffffffd);
    run("divovf", 4'd3, 32'h80000000, 32'hffffffff, 10, 4'd0);
    rd("divovf", 32'd0, 32'h80000000);

    tick();
    bus.mduOpE = 4'd7;
    bus.aE = 32'h1234;
    tick();
    bus.mduOpE = 4'd8;
    bus.aE = 32'h5678;
    tick();
    rd("mt", 32'h1234, 32'h5678);
    run("divz", 4'd4, 32'd99, 32'd0, 10, 4'd1);
    rd("divz", 32'h1234, 32'h5678);

    run("iso", 4'd2, 32'd6, 32'd7, 5, 4'd0);
    rd("iso", 32'd0, 32'd42);
    run("b2b", 4'd4, 32'd100, 32'd7, 10, 4'd0);
    rd("b2b", 32'd2, 32'd14);

    bus.mduOpE = 4'd3;
    bus.aE = 32'd50;
    bus.bE = 32'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.mduOpE = 4'd0;
    end
    #1 chk("abort pre", 32'(bus.busyE), 32'd1);
    rstN = 1'b0;
    #1 chk("abort busy", 32'(bus.busyE), 32'd0);
    rd("abort", 32'd0, 32'd0);
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("abort idle", 32'(bus.busyE), 32'd0);
    rd("abort late", 32'd0, 32'd0);
    run("fresh", 4'd1, 32'd3, 32'd3, 5, 4'd0);
    rd("fresh", 32'd0, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the HI/LO registers.
- It serves MFHI/MFLO/MTHI/MTLO.
- It exports Start$E and Busy$E to the stall controller. That controller holds any MDU-class instruction in D while either signal is high.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy$E stays high for MULT/MULTU (1..15)
- DIV_CYCLES, 10, number of cycles Busy$E stays high for DIV/DIVU (1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- MDUOp$E  input  4  op of instruction in E: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 treated as NONE
- A$E  input  32  forwarded rs value
- B$E  input  32  forwarded rt value
- Start$E  output  1  combinational; high when MDUOp$E is 1..4 and Busy$E is 0
- Busy$E  output  1  registered; high while an operation is in flight
- Out$E  output  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise

Behaviour:
- Reset (reset_n=0, async): HI=0, LO=0, Busy$E=0, counter=0, operand/op latches=0. Start$E is combinational and its reset value is 0 because Busy$E=0 and only MDUOp$E can drive it. Out$E=0 unless MDUOp$E is 5/6.
- States: IDLE (Busy$E=0) and RUN (Busy$E=1). The state is encoded by Busy$E plus a 4-bit down-counter.
- IDLE -> RUN:
  - Occurs on the edge ending a cycle with Start$E=1.
  - Latch A$E, B$E and op.
  - Counter loads MULT_CYCLES (ops 1/2) or DIV_CYCLES (ops 3/4).
  - Busy$E<=1.
- RUN:
  - Counter decrements every edge.
  - The edge at which the counter equals 1 writes the result to HI/LO, sets Busy$E<=0 and returns to IDLE.
  - Busy$E is therefore high for exactly N cycles. A start in cycle T gives Busy$E high in cycles T+1..T+N.
  - MFHI/MFLO in cycle T+N+1 returns the new value.
- Result rules:
  - MULT: {HI,LO} = signed 64-bit A*B.
  - MULTU: {HI,LO} = unsigned 64-bit A*B.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend (A).
  - DIV overflow case A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (B=0, DIV or DIVU): full latency still elapses, and HI/LO are left unchanged.
- Results are computed from the latched operands. Changes on A$E/B$E during RUN have no effect.
- MTHI/MTLO:
  - Write HI/LO from A$E on the edge ending the cycle in which the op is present and Busy$E=0.
  - Ignored while Busy$E=1; the stall controller guarantees this never happens.
- MDUOp$E 1..4 while Busy$E=1: ignored, no restart, Start$E stays 0.
- MFHI/MFLO while Busy$E=1: Out$E shows the current (old) HI/LO. This is a protocol violation that the stall controller prevents.
- Reset asserted during RUN: immediately aborts, Busy$E=0, HI/LO=0. No partial result is written.
- Back-to-back ops:
  - A new start is permitted in the first IDLE cycle after completion.
  - Start and completion never coincide, because Start$E is gated by Busy$E.
- Internal implementation is free: iterative, or a single-cycle operator with a delayed write. Only the cycle-exact timing of HI/LO visibility and Busy$E is specified.

Test Plan:
1. Reset then MFHI/MFLO: reset_n low mid-sim, release; MDUOp$E=5 then 6 -> Out$E=0 both; Busy$E=0, Start$E=0 throughout.
2. MULT signed:
   - Stimulus: A=0xFFFFFFFE (-2), B=3, op=1 in cycle T.
   - Required: Start$E=1 in T; Busy$E high T+1..T+5, low T+6.
   - Then MFHI gives 0xFFFFFFFF and MFLO gives 0xFFFFFFFA.
   - The same operands with MULTU give HI=0x00000002, LO=0xFFFFFFFA.
3. DIV signed and overflow:
   - Stimulus: A=-7 (0xFFFFFFF9), B=2, op=3.
   - Required: Busy$E high exactly 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
4. Divide by zero and ignored ops:
   - Preload with MTHI A=0x1234 and MTLO A=0x5678.
   - DIVU B=0 -> 10 busy cycles, then HI=0x1234, LO=0x5678.
   - Present op=1 during busy -> no restart; Busy$E falls on schedule.
5. Operand isolation and back-to-back:
   - Start MULTU 6*7, then change A$E/B$E every busy cycle -> LO=42.
   - Issue DIVU 100/7 in the first idle cycle -> Start$E=1, LO=14, HI=2 after 10 cycles.
6. Reset mid-operation: start DIV, assert reset_n low at busy cycle 4 -> Busy$E=0 immediately, HI=LO=0, no later write; a fresh MULT 3*3 after release gives LO=9.
